// File: rtl/osc_acq_sched.sv
// Acquisition scheduler: arm -> trigger wait -> capture -> display -> holdoff, plus key-driven scope settings.
// Define OSC_AUTO_TIMEOUT_EN to enable the AUTO-mode forced trigger; otherwise AUTO behaves as NORMAL.
module osc_acq_sched #(
  parameter logic [23:0] AUTO_TIMEOUT = 24'd4_000_000,
  parameter logic [15:0] HOLDOFF_CYC  = 16'd1000,
  parameter logic [7:0]  LVL_STEP     = 8'd5,
  parameter logic [7:0]  LVL_RST      = 8'd128,
  parameter logic [4:0]  TB_RST       = 5'd2,
  parameter logic [4:0]  TB_MAX       = 5'd31
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_run_i,
  input  logic       key_mode_i,
  input  logic       key_lvl_up_i,
  input  logic       key_lvl_dn_i,
  input  logic       key_tb_up_i,
  input  logic       key_tb_dn_i,
  input  logic       key_edge_i,
  input  logic       pretrig_ok_i,
  input  logic       trig_hit_i,
  input  logic       cap_done_i,
  input  logic       frame_done_i,
  output logic       arm_o,
  output logic       force_trig_o,
  output logic       disp_en_o,
  output logic       running_o,
  output logic [7:0] trig_level_o,
  output logic       trig_edge_o,
  output logic [4:0] adc_clk_sel_o,
  output logic [1:0] trig_mode_o,
  output logic [2:0] state_o
);

`ifdef OSC_AUTO_TIMEOUT_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_STOP = 3'd0, ST_ARM = 3'd1, ST_WAIT = 3'd2,
    ST_CAPT = 3'd3, ST_SHOW = 3'd4, ST_HOLD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        force_q, force_d;
  logic        arm_q, disp_q, running_q;
  logic [7:0]  lvl_q, lvl_d;
  logic        edge_q, edge_d;
  logic [4:0]  tb_q, tb_d;
  logic [1:0]  mode_q, mode_d;
  logic [8:0]  lvl_sum, lvl_dif;
  logic        rearm_key, timeout;

  assign lvl_sum   = {1'b0, lvl_q} + {1'b0, LVL_STEP};
  assign lvl_dif   = {1'b0, lvl_q} - {1'b0, LVL_STEP};
  assign rearm_key = key_edge_i | (key_tb_up_i ^ key_tb_dn_i);
  assign timeout   = AUTO_EN && (mode_q == 2'd0) && (cnt_q == AUTO_TIMEOUT - 24'd1);

  always_comb begin
    lvl_d  = lvl_q;
    tb_d   = tb_q;
    edge_d = edge_q ^ key_edge_i;
    mode_d = mode_q;
    if (key_lvl_up_i && !key_lvl_dn_i) lvl_d = lvl_sum[8] ? 8'hFF : lvl_sum[7:0];
    if (key_lvl_dn_i && !key_lvl_up_i) lvl_d = lvl_dif[8] ? 8'h00 : lvl_dif[7:0];
    if (key_tb_up_i && !key_tb_dn_i)   tb_d  = (tb_q >= TB_MAX) ? TB_MAX : tb_q + 5'd1;
    if (key_tb_dn_i && !key_tb_up_i)   tb_d  = (tb_q == 5'd0) ? 5'd0 : tb_q - 5'd1;
    if (key_mode_i)                    mode_d = (mode_q >= 2'd2) ? 2'd0 : mode_q + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    force_d = 1'b0;
    case (state_q)
      ST_STOP: if (key_run_i) state_d = ST_ARM;
      ST_ARM:  if (!rearm_key && pretrig_ok_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rearm_key)       state_d = ST_ARM;
        else if (trig_hit_i) state_d = ST_CAPT;
        else if (timeout) begin
          state_d = ST_CAPT;
          force_d = 1'b1;
        end else if (AUTO_EN) cnt_d = cnt_q + 24'd1;
      end
      ST_CAPT: begin
        if (rearm_key)       state_d = ST_ARM;
        else if (cap_done_i) state_d = ST_SHOW;
      end
      ST_SHOW: if (frame_done_i) state_d = (mode_q == 2'd2) ? ST_STOP : ST_HOLD;
      ST_HOLD: begin
        if (cnt_q == {8'd0, HOLDOFF_CYC} - 24'd1) state_d = ST_ARM;
        else cnt_d = cnt_q + 24'd1;
      end
      default: state_d = ST_STOP;
    endcase
    // Stop key aborts whatever is in flight, including a same-cycle forced trigger.
    if (key_run_i && running_q) begin
      state_d = ST_STOP;
      cnt_d   = '0;
      force_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_STOP;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      arm_q     <= 1'b0;
      disp_q    <= 1'b0;
      running_q <= 1'b0;
      lvl_q     <= LVL_RST;
      edge_q    <= 1'b1;
      tb_q      <= TB_RST;
      mode_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      force_q   <= force_d;
      arm_q     <= (state_d == ST_ARM) || (state_d == ST_WAIT);
      disp_q    <= (state_d == ST_SHOW);
      running_q <= (state_d != ST_STOP);
      lvl_q     <= lvl_d;
      edge_q    <= edge_d;
      tb_q      <= tb_d;
      mode_q    <= mode_d;
    end
  end

  assign arm_o         = arm_q;
  assign force_trig_o  = force_q;
  assign disp_en_o     = disp_q;
  assign running_o     = running_q;
  assign trig_level_o  = lvl_q;
  assign trig_edge_o   = edge_q;
  assign adc_clk_sel_o = tb_q;
  assign trig_mode_o   = mode_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_osc_acq_sched.sv
// Directed bench for osc_acq_sched; expectations depend on whether OSC_AUTO_TIMEOUT_EN is defined.
module tb_osc_acq_sched;
  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       key_run_i = 1'b0, key_mode_i = 1'b0, key_lvl_up_i = 1'b0, key_lvl_dn_i = 1'b0;
  logic       key_tb_up_i = 1'b0, key_tb_dn_i = 1'b0, key_edge_i = 1'b0;
  logic       pretrig_ok_i = 1'b0, trig_hit_i = 1'b0, cap_done_i = 1'b0, frame_done_i = 1'b0;
  logic       arm_o, force_trig_o, disp_en_o, running_o, trig_edge_o;
  logic [7:0] trig_level_o;
  logic [4:0] adc_clk_sel_o;
  logic [1:0] trig_mode_o;
  logic [2:0] state_o;
  int         checks = 0;
  int         errors = 0;
  logic       seen_bad;

  osc_acq_sched #(.AUTO_TIMEOUT(24'd100)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .key_run_i(key_run_i), .key_mode_i(key_mode_i),
    .key_lvl_up_i(key_lvl_up_i), .key_lvl_dn_i(key_lvl_dn_i),
    .key_tb_up_i(key_tb_up_i), .key_tb_dn_i(key_tb_dn_i), .key_edge_i(key_edge_i),
    .pretrig_ok_i(pretrig_ok_i), .trig_hit_i(trig_hit_i),
    .cap_done_i(cap_done_i), .frame_done_i(frame_done_i),
    .arm_o(arm_o), .force_trig_o(force_trig_o), .disp_en_o(disp_en_o),
    .running_o(running_o), .trig_level_o(trig_level_o), .trig_edge_o(trig_edge_o),
    .adc_clk_sel_o(adc_clk_sel_o), .trig_mode_o(trig_mode_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_running", 32'(running_o), 0);
    chk("rst_level", 32'(trig_level_o), 128);
    chk("rst_edge", 32'(trig_edge_o), 1);
    chk("rst_tb", 32'(adc_clk_sel_o), 2);
    chk("rst_mode", 32'(trig_mode_o), 0);
    chk("rst_arm", 32'(arm_o), 0);
    chk("rst_force", 32'(force_trig_o), 0);
    chk("rst_disp", 32'(disp_en_o), 0);
    rst_n_i = 1'b1;
    tick();

    // Main loop: STOP -> ARM -> WAIT -> CAPT -> SHOW -> HOLD -> ARM
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    chk("run_arm", 32'(state_o), 1);
    chk("run_running", 32'(running_o), 1);
    chk("run_arm_o", 32'(arm_o), 1);
    pretrig_ok_i = 1'b1; tick();
    chk("wait", 32'(state_o), 2);
    chk("wait_arm_o", 32'(arm_o), 1);
    trig_hit_i = 1'b1; tick(); trig_hit_i = 1'b0;
    chk("capt", 32'(state_o), 3);
    chk("capt_arm_o", 32'(arm_o), 0);
    cap_done_i = 1'b1; tick(); cap_done_i = 1'b0;
    chk("show", 32'(state_o), 4);
    chk("show_disp", 32'(disp_en_o), 1);
    frame_done_i = 1'b1; tick(); frame_done_i = 1'b0;
    chk("hold", 32'(state_o), 5);
    chk("hold_disp", 32'(disp_en_o), 0);
    repeat (999) tick();
    chk("hold_999", 32'(state_o), 5);
    tick();
    chk("hold_rearm", 32'(state_o), 1);
    tick();
    chk("rewait", 32'(state_o), 2);

    // Settings keys in WAIT re-arm
    key_tb_up_i = 1'b1; tick(); key_tb_up_i = 1'b0;
    chk("tbup_val", 32'(adc_clk_sel_o), 3);
    chk("tbup_rearm", 32'(state_o), 1);
    tick();
    chk("tbup_wait", 32'(state_o), 2);
    key_edge_i = 1'b1; tick(); key_edge_i = 1'b0;
    chk("edge_val", 32'(trig_edge_o), 0);
    chk("edge_rearm", 32'(state_o), 1);
    tick();

    // Abort in CAPT
    trig_hit_i = 1'b1; tick(); trig_hit_i = 1'b0;
    chk("capt2", 32'(state_o), 3);
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    chk("abort_state", 32'(state_o), 0);
    chk("abort_running", 32'(running_o), 0);
    cap_done_i = 1'b1; tick(); cap_done_i = 1'b0;
    chk("late_capdone", 32'(state_o), 0);

    // SINGLE mode
    key_mode_i = 1'b1; tick(); key_mode_i = 1'b0;
    chk("mode_normal", 32'(trig_mode_o), 1);
    key_mode_i = 1'b1; tick(); key_mode_i = 1'b0;
    chk("mode_single", 32'(trig_mode_o), 2);
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    tick();
    chk("single_wait", 32'(state_o), 2);
    trig_hit_i = 1'b1; tick(); trig_hit_i = 1'b0;
    cap_done_i = 1'b1; tick(); cap_done_i = 1'b0;
    chk("single_show", 32'(state_o), 4);
    frame_done_i = 1'b1; tick(); frame_done_i = 1'b0;
    chk("single_stop", 32'(state_o), 0);
    chk("single_running", 32'(running_o), 0);
    repeat (5) tick();
    chk("single_no_rearm", 32'(state_o), 0);

    // AUTO timeout
    key_mode_i = 1'b1; tick(); key_mode_i = 1'b0;
    chk("mode_auto", 32'(trig_mode_o), 0);
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    tick();
    chk("auto_wait", 32'(state_o), 2);
    seen_bad = 1'b0;
    repeat (99) begin
      tick();
      if (force_trig_o !== 1'b0 || state_o !== 3'd2) seen_bad = 1'b1;
    end
    chk("auto_pre_timeout", 32'(seen_bad), 0);
    tick();
`ifdef OSC_AUTO_TIMEOUT_EN
    chk("auto_force", 32'(force_trig_o), 1);
    chk("auto_capt", 32'(state_o), 3);
    tick();
    chk("auto_force_pulse", 32'(force_trig_o), 0);
    chk("auto_capt_stay", 32'(state_o), 3);
`else
    chk("noauto_force", 32'(force_trig_o), 0);
    chk("noauto_wait", 32'(state_o), 2);
    repeat (150) tick();
    chk("noauto_force2", 32'(force_trig_o), 0);
    chk("noauto_wait2", 32'(state_o), 2);
`endif
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    chk("auto_stop", 32'(state_o), 0);

    // Trigger level saturation (in STOP)
    key_lvl_up_i = 1'b1;
    repeat (25) tick();
    chk("lvl_253", 32'(trig_level_o), 253);
    tick();
    chk("lvl_sat_hi", 32'(trig_level_o), 255);
    tick(); key_lvl_up_i = 1'b0;
    chk("lvl_27", 32'(trig_level_o), 255);
    key_lvl_dn_i = 1'b1;
    repeat (50) tick();
    chk("lvl_5", 32'(trig_level_o), 5);
    repeat (2) tick(); key_lvl_dn_i = 1'b0;
    chk("lvl_sat_lo", 32'(trig_level_o), 0);
    key_lvl_up_i = 1'b1; tick();
    key_lvl_dn_i = 1'b1; tick(); key_lvl_up_i = 1'b0; key_lvl_dn_i = 1'b0;
    chk("lvl_both", 32'(trig_level_o), 5);

    // Timebase saturation (in STOP, no state change)
    key_tb_dn_i = 1'b1;
    repeat (4) tick(); key_tb_dn_i = 1'b0;
    chk("tb_sat_lo", 32'(adc_clk_sel_o), 0);
    chk("tb_stop_state", 32'(state_o), 0);
    key_tb_up_i = 1'b1;
    repeat (40) tick();
    key_tb_dn_i = 1'b1; tick(); key_tb_up_i = 1'b0; key_tb_dn_i = 1'b0;
    chk("tb_sat_hi_both", 32'(adc_clk_sel_o), 31);

    // Level key in WAIT does not re-arm
    key_run_i = 1'b1; tick(); key_run_i = 1'b0;
    tick();
    key_lvl_up_i = 1'b1; tick(); key_lvl_up_i = 1'b0;
    chk("lvl_wait_val", 32'(trig_level_o), 10);
    chk("lvl_wait_state", 32'(state_o), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
